// File: rtl/sfq_cell_pkg.sv
// Shared constants and helpers for SFQ cell models.
// Holds the collide-mode encodings, the pulse-counter width and a saturating incrementer.
package sfq_cell_pkg;

   localparam int COLLIDE_STORE   = 0;
   localparam int COLLIDE_CAPTURE = 1;
   localparam int CNT_W           = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sfq_dro_chain.sv
// One channel: a DEPTH-stage chain of destructive-readout loops plus its double-set flag.
// Ports: clk, reset, din_i, rd_i, err_clr_i in; dout_o, empty_o, err_dbl_o out.
module sfq_dro_chain
   import sfq_cell_pkg::*;
#(
   parameter int DEPTH        = 3,
   parameter int COLLIDE_MODE = COLLIDE_STORE
) (
   input  logic clk,
   input  logic reset,
   input  logic din_i,
   input  logic rd_i,
   input  logic err_clr_i,
   output logic dout_o,
   output logic empty_o,
   output logic err_dbl_o
);

   logic [DEPTH-1:0] stg_q, stg_d;
   logic             dout_q, dout_d;
   logic             err_q, err_d;
   logic             dbl;

   always_comb begin
      stg_d  = stg_q;
      dout_d = 1'b0;
      dbl    = 1'b0;
      if (rd_i) begin
         dout_d = stg_q[DEPTH-1];
         // stage s takes stage s-1; stage 0 empties
         stg_d  = stg_q << 1;
         if (din_i) begin
            if (COLLIDE_MODE == COLLIDE_CAPTURE) begin
               // pulse rides the shift: merges with what stage 0 passes on
               dbl = stg_q[0];
               if (DEPTH == 1) dout_d = 1'b1;
               else            stg_d  = stg_d | DEPTH'(2);
            end else begin
               stg_d[0] = 1'b1;
            end
         end
      end else if (din_i) begin
         dbl      = stg_q[0];
         stg_d[0] = 1'b1;
      end
      // a fresh error outranks a simultaneous clear
      err_d = (err_q & ~err_clr_i) | dbl;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stg_q  <= '0;
         dout_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         stg_q  <= stg_d;
         dout_q <= dout_d;
         err_q  <= err_d;
      end
   end

   assign dout_o    = dout_q;
   assign empty_o   = ~|stg_q;
   assign err_dbl_o = err_q;

endmodule

// File: rtl/sfq_dro_shift_bank.sv
// WIDTH-channel bank of DRO shift chains sharing one readout pulse, with pulse-rule flags.
// Ports: clk, reset, din, rd, err_clr in; dout, empty, err_dbl, err_rd_empty (+ pcount with SFQ_PULSE_COUNT_EN) out.
module sfq_dro_shift_bank
   import sfq_cell_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int DEPTH        = 3,
   parameter int COLLIDE_MODE = COLLIDE_STORE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   din,
   input  logic               rd,
   input  logic               err_clr,
   output logic [WIDTH-1:0]   dout,
`ifdef SFQ_PULSE_COUNT_EN
   output logic [WIDTH*CNT_W-1:0] pcount,
`endif
   output logic               empty,
   output logic [WIDTH-1:0]   err_dbl,
   output logic               err_rd_empty
);

   logic [WIDTH-1:0] ch_empty;
   logic             rde_q, rde_d;

   for (genvar c = 0; c < WIDTH; c++) begin : g_ch
      sfq_dro_chain #(
         .DEPTH        (DEPTH),
         .COLLIDE_MODE (COLLIDE_MODE)
      ) u_chain (
         .clk       (clk),
         .reset     (reset),
         .din_i     (din[c]),
         .rd_i      (rd),
         .err_clr_i (err_clr),
         .dout_o    (dout[c]),
         .empty_o   (ch_empty[c]),
         .err_dbl_o (err_dbl[c])
      );

`ifdef SFQ_PULSE_COUNT_EN
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clk) begin
         if (reset)        cnt_q <= '0;
         else if (dout[c]) cnt_q <= sat_inc(cnt_q);
      end
      assign pcount[c*CNT_W +: CNT_W] = cnt_q;
`endif
   end

   assign empty = &ch_empty;

   always_comb begin
      rde_d = (rde_q & ~err_clr) | (rd & empty);
   end

   always_ff @(posedge clk) begin
      if (reset) rde_q <= 1'b0;
      else       rde_q <= rde_d;
   end

   assign err_rd_empty = rde_q;

endmodule

// File: tb/tb_sfq_dro_shift_bank.sv
// Directed, table-driven bench for sfq_dro_shift_bank.
// Runs a store-mode and a capture-mode instance side by side on shared stimulus.
module tb_sfq_dro_shift_bank;
   import sfq_cell_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] din;
   logic         rd;
   logic         err_clr;

   logic [W-1:0] dout0, dout1;
   logic         empty0, empty1;
   logic [W-1:0] dbl0, dbl1;
   logic         rde0, rde1;
`ifdef SFQ_PULSE_COUNT_EN
   logic [W*CNT_W-1:0] pc0, pc1;
`endif

   always #5 clk = ~clk;

   sfq_dro_shift_bank #(.WIDTH(W), .DEPTH(3), .COLLIDE_MODE(0)) u_m0 (
      .clk(clk), .reset(reset), .din(din), .rd(rd), .err_clr(err_clr),
      .dout(dout0),
`ifdef SFQ_PULSE_COUNT_EN
      .pcount(pc0),
`endif
      .empty(empty0), .err_dbl(dbl0), .err_rd_empty(rde0)
   );

   sfq_dro_shift_bank #(.WIDTH(W), .DEPTH(3), .COLLIDE_MODE(1)) u_m1 (
      .clk(clk), .reset(reset), .din(din), .rd(rd), .err_clr(err_clr),
      .dout(dout1),
`ifdef SFQ_PULSE_COUNT_EN
      .pcount(pc1),
`endif
      .empty(empty1), .err_dbl(dbl1), .err_rd_empty(rde1)
   );

   typedef struct {
      logic         rst;
      logic [W-1:0] din;
      logic         rd;
      logic         clr;
      logic [W-1:0] dout;
      logic         empty;
      logic [W-1:0] dbl;
      logic         rde;
      logic [W-1:0] dout1;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step(input logic r, input logic [W-1:0] d, input logic p, input logic c);
      reset   = r;
      din     = d;
      rd      = p;
      err_clr = c;
      @(posedge clk);
      #1;
   endtask

   vec_t tv[$];

   function automatic vec_t mk(input logic r, input logic [W-1:0] d, input logic p,
                               input logic c, input logic [W-1:0] o, input logic e,
                               input logic [W-1:0] b, input logic re, input logic [W-1:0] o1);
      vec_t v;
      v.rst = r; v.din = d; v.rd = p; v.clr = c;
      v.dout = o; v.empty = e; v.dbl = b; v.rde = re; v.dout1 = o1;
      return v;
   endfunction

   initial begin
      reset = 1'b1; din = '0; rd = 1'b0; err_clr = 1'b0;

      //            rst din     rd clr  dout    emp dbl     rde dout1
      tv.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000)); // reset
      tv.push_back(mk(0, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000)); // load ch0
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0001, 1, 4'b0000, 0, 4'b0001)); // 3rd rd
      tv.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000)); // one cycle
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 1, 4'b0000, 1, 4'b0000)); // rd on empty
      tv.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b0000)); // sticky
      tv.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 1, 4'b0000, 0, 4'b0000)); // clear
      tv.push_back(mk(0, 4'b0100, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0100, 0, 0, 4'b0000, 0, 4'b0100, 0, 4'b0000)); // double set
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0100, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0100, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0100, 1, 4'b0100, 0, 4'b0100)); // single pulse
      tv.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 1, 4'b0000, 0, 4'b0000)); // clear dbl
      tv.push_back(mk(0, 4'b1000, 1, 0, 4'b0000, 0, 4'b0000, 1, 4'b0000)); // collision
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 1, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 1, 4'b1000)); // capture: 2 rd
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b1000, 1, 4'b0000, 1, 4'b0000)); // store: 3 rd
      tv.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, 1, 4'b0000, 1, 4'b0000)); // new err wins
      tv.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 1, 4'b0000, 0, 4'b0000));
      tv.push_back(mk(0, 4'b1111, 0, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
      tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000));
      tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000)); // reset + rd
      tv.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000));

      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].rst, tv[i].din, tv[i].rd, tv[i].clr);
         chk($sformatf("v%0d dout", i),  32'(dout0),  32'(tv[i].dout));
         chk($sformatf("v%0d empty", i), 32'(empty0), 32'(tv[i].empty));
         chk($sformatf("v%0d err_dbl", i), 32'(dbl0), 32'(tv[i].dbl));
         chk($sformatf("v%0d err_rd_empty", i), 32'(rde0), 32'(tv[i].rde));
         chk($sformatf("v%0d dout_cap", i), 32'(dout1), 32'(tv[i].dout1));
      end

      // back-to-back readouts give consecutive independent pulses
      step(0, 4'b0011, 0, 0);
      step(0, 4'b0000, 1, 0);
      step(0, 4'b0001, 0, 0);
      step(0, 4'b0000, 1, 0);
      chk("b2b pre", 32'(dout0), 32'h0);
      step(0, 4'b0000, 1, 0);
      chk("b2b first", 32'(dout0), 32'h3);
      chk("b2b first cap", 32'(dout1), 32'h3);
      step(0, 4'b0000, 1, 0);
      chk("b2b second", 32'(dout0), 32'h1);
      chk("b2b empty", 32'(empty0), 32'h1);
      step(0, 4'b0000, 0, 0);
      chk("b2b idle", 32'(dout0), 32'h0);

      // capture-mode merge: stage 0 full plus colliding set
      step(1, 4'b0000, 0, 0);
      step(0, 4'b0010, 0, 0);
      step(0, 4'b0010, 1, 0);
      chk("merge dbl cap", 32'(dbl1), 32'h2);
      chk("merge dbl store", 32'(dbl0), 32'h0);
      step(0, 4'b0000, 1, 0);
      step(0, 4'b0000, 1, 0);
      chk("merge out cap", 32'(dout1), 32'h2);
      step(0, 4'b0000, 1, 0);
      chk("merge single", 32'(dout1), 32'h0);
      chk("merge empty cap", 32'(empty1), 32'h1);

`ifdef SFQ_PULSE_COUNT_EN
      step(1, 4'b0000, 0, 0);
      for (int k = 0; k < 70000; k++) step(0, 4'b0001, 1, 0);
      for (int k = 0; k < 5; k++) step(0, 4'b0000, 1, 1);
      chk("pcount ch0", 32'(pc0[15:0]), 32'hFFFF);
      chk("pcount others", 32'(pc0[W*CNT_W-1:CNT_W]), 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
